// File: rtl/glb_bank_ctrl.sv
// glb_bank_ctrl
//   Request-side controller for one GLB bank. Arbitrates a write channel and a
//   read channel (valid/ready) onto a single-port bank memory, expands byte
//   strobes into a per-bit write mask, and carries read tags alongside the
//   memory latency so each response leaves with its tag.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   wr_req_*              write request channel (addr, data, byte strobes)
//   rd_req_*              read request channel (addr, tag)
//   rd_rsp_*              read response (valid, data, tag); no backpressure
//   mem_*                 registered single-port memory interface; mem_data_out
//                         is the memory's read data, held between reads
module glb_bank_ctrl #(
  parameter int unsigned BANK_ADDR_WIDTH  = 17,
  parameter int unsigned BANK_DATA_WIDTH  = 64,
  parameter int unsigned BANK_BYTE_OFFSET = 3,
  parameter int unsigned MEM_RD_LATENCY   = 3,
  parameter int unsigned TAG_WIDTH        = 4,
  parameter int unsigned STARVE_MAX       = 4
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         wr_req_valid,
  output logic                         wr_req_ready,
  input  logic [BANK_ADDR_WIDTH-1:0]   wr_req_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   wr_req_data,
  input  logic [BANK_DATA_WIDTH/8-1:0] wr_req_strb,

  input  logic                         rd_req_valid,
  output logic                         rd_req_ready,
  input  logic [BANK_ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic [TAG_WIDTH-1:0]         rd_req_tag,

  output logic                         rd_rsp_valid,
  output logic [BANK_DATA_WIDTH-1:0]   rd_rsp_data,
  output logic [TAG_WIDTH-1:0]         rd_rsp_tag,

  output logic                         mem_ren,
  output logic                         mem_wen,
  output logic [BANK_ADDR_WIDTH-1:0]   mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]   mem_data_in,
  output logic [BANK_DATA_WIDTH-1:0]   mem_data_in_bit_sel,
  input  logic [BANK_DATA_WIDTH-1:0]   mem_data_out
);

  localparam int unsigned BYTES_PER_WORD = 1 << BANK_BYTE_OFFSET;
  localparam int unsigned PIPE_DEPTH     = 1 + MEM_RD_LATENCY;
  localparam logic [3:0]  STARVE_LAST    = 4'(STARVE_MAX - 1);

  logic                                   rd_acc;
  logic                                   wr_acc;
  logic                                   wr_access;

  logic [3:0]                             starve_cnt_d, starve_cnt_q;
  logic                                   force_rd_d, force_rd_q;

  logic                                   mem_ren_d, mem_ren_q;
  logic                                   mem_wen_d, mem_wen_q;
  logic [BANK_ADDR_WIDTH-1:0]             mem_addr_d, mem_addr_q;
  logic [BANK_DATA_WIDTH-1:0]             mem_data_in_d, mem_data_in_q;
  logic [BANK_DATA_WIDTH-1:0]             bit_sel_d, bit_sel_q;

  logic [PIPE_DEPTH-1:0]                  pipe_vld_d, pipe_vld_q;
  logic [PIPE_DEPTH-1:0][TAG_WIDTH-1:0]   pipe_tag_d, pipe_tag_q;
  logic                                   rsp_valid_d, rsp_valid_q;
  logic [TAG_WIDTH-1:0]                   rsp_tag_d, rsp_tag_q;

  // Writes win by default; once a read has starved long enough the priority
  // flips until that read is taken. The two readies are never both usable.
  always_comb begin
    if (force_rd_q) begin
      rd_req_ready = 1'b1;
      wr_req_ready = ~rd_req_valid;
    end else begin
      wr_req_ready = 1'b1;
      rd_req_ready = ~wr_req_valid;
    end
  end

  assign rd_acc    = rd_req_valid & rd_req_ready;
  assign wr_acc    = wr_req_valid & wr_req_ready;
  // A write with no strobes completes its handshake but never reaches memory.
  assign wr_access = wr_acc & (|wr_req_strb);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_rd_d   = force_rd_q;
    if (rd_acc) begin
      starve_cnt_d = '0;
      force_rd_d   = 1'b0;
    end else if (rd_req_valid) begin
      if (starve_cnt_q == STARVE_LAST) begin
        starve_cnt_d = '0;
        force_rd_d   = 1'b1;
      end else begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    mem_ren_d     = rd_acc;
    mem_wen_d     = wr_access;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    bit_sel_d     = bit_sel_q;
    if (rd_acc) begin
      mem_addr_d = rd_req_addr;
    end else if (wr_access) begin
      mem_addr_d    = wr_req_addr;
      mem_data_in_d = wr_req_data;
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        bit_sel_d[i*8 +: 8] = {8{wr_req_strb[i]}};
      end
    end
  end

  // Tag pipeline loads on acceptance; the registered response stage behind it
  // lines the tag up with the memory's data_out, one edge after the last stage.
  always_comb begin
    pipe_vld_d[0] = rd_acc;
    pipe_tag_d[0] = rd_req_tag;
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
    rsp_valid_d = pipe_vld_q[PIPE_DEPTH-1];
    rsp_tag_d   = pipe_tag_q[PIPE_DEPTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q  <= '0;
      force_rd_q    <= 1'b0;
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      bit_sel_q     <= '0;
      pipe_vld_q    <= '0;
      pipe_tag_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      force_rd_q    <= force_rd_d;
      mem_ren_q     <= mem_ren_d;
      mem_wen_q     <= mem_wen_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      bit_sel_q     <= bit_sel_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_tag_q    <= pipe_tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tag_q     <= rsp_tag_d;
    end
  end

  assign mem_ren             = mem_ren_q;
  assign mem_wen             = mem_wen_q;
  assign mem_addr            = mem_addr_q;
  assign mem_data_in         = mem_data_in_q;
  assign mem_data_in_bit_sel = bit_sel_q;
  assign rd_rsp_valid        = rsp_valid_q;
  assign rd_rsp_tag          = rsp_tag_q;
  assign rd_rsp_data         = mem_data_out;

endmodule

// File: tb/tb_glb_bank_ctrl.sv
// tb_glb_bank_ctrl
//   Directed bench for glb_bank_ctrl with a behavioural single-port bank
//   memory (write at the sampling edge, read data valid MEM_RD_LATENCY edges
//   after ren is sampled, held between reads).
module tb_glb_bank_ctrl;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 4;

  logic            clk;
  logic            reset;
  logic            wr_req_valid, wr_req_ready;
  logic [AW-1:0]   wr_req_addr;
  logic [DW-1:0]   wr_req_data;
  logic [DW/8-1:0] wr_req_strb;
  logic            rd_req_valid, rd_req_ready;
  logic [AW-1:0]   rd_req_addr;
  logic [TW-1:0]   rd_req_tag;
  logic            rd_rsp_valid;
  logic [DW-1:0]   rd_rsp_data;
  logic [TW-1:0]   rd_rsp_tag;
  logic            mem_ren, mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_in, mem_data_in_bit_sel, mem_data_out;

  int n_checks = 0;
  int n_errors = 0;

  glb_bank_ctrl #(
    .BANK_ADDR_WIDTH (AW),
    .BANK_DATA_WIDTH (DW),
    .BANK_BYTE_OFFSET(3),
    .MEM_RD_LATENCY  (3),
    .TAG_WIDTH       (TW),
    .STARVE_MAX      (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .wr_req_valid       (wr_req_valid),
    .wr_req_ready       (wr_req_ready),
    .wr_req_addr        (wr_req_addr),
    .wr_req_data        (wr_req_data),
    .wr_req_strb        (wr_req_strb),
    .rd_req_valid       (rd_req_valid),
    .rd_req_ready       (rd_req_ready),
    .rd_req_addr        (rd_req_addr),
    .rd_req_tag         (rd_req_tag),
    .rd_rsp_valid       (rd_rsp_valid),
    .rd_rsp_data        (rd_rsp_data),
    .rd_rsp_tag         (rd_rsp_tag),
    .mem_ren            (mem_ren),
    .mem_wen            (mem_wen),
    .mem_addr           (mem_addr),
    .mem_data_in        (mem_data_in),
    .mem_data_in_bit_sel(mem_data_in_bit_sel),
    .mem_data_out       (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank memory, 128 words.
  logic [DW-1:0] mem [128];
  logic          rp_v [3];
  logic [DW-1:0] rp_d [3];

  function automatic logic [DW-1:0] init_word(input int idx);
    return 64'hDEAD_BEEF_0000_0000 | 64'(idx);
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = init_word(i);
    for (int i = 0; i < 3; i++) begin
      rp_v[i] = 1'b0;
      rp_d[i] = '0;
    end
    mem_data_out = '0;
  end

  always @(posedge clk) begin
    if (mem_wen)
      mem[mem_addr[9:3]] <= (mem[mem_addr[9:3]] & ~mem_data_in_bit_sel) |
                            (mem_data_in & mem_data_in_bit_sel);
    rp_v[0] <= mem_ren;
    rp_d[0] <= mem[mem_addr[9:3]];
    rp_v[1] <= rp_v[0];
    rp_d[1] <= rp_d[0];
    rp_v[2] <= rp_v[1];
    rp_d[2] <= rp_d[1];
    if (rp_v[2]) mem_data_out <= rp_d[2];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after the acceptance edge of a lone read.
  task automatic expect_rsp(input string name, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    step();
    step();
    step();
    check({name, "_rsp_early"}, 64'(rd_rsp_valid), 64'd0);
    step();
    check({name, "_rsp_valid"}, 64'(rd_rsp_valid), 64'd1);
    check({name, "_rsp_tag"}, 64'(rd_rsp_tag), 64'(tag));
    check({name, "_rsp_data"}, rd_rsp_data, data);
    step();
    check({name, "_rsp_single"}, 64'(rd_rsp_valid), 64'd0);
  endtask

  logic [DW-1:0] merged;
  logic [DW-1:0] b2b_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    merged = 64'hDEAD_BEEF_5566_7788;
    reset = 1'b1;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_tag = '0;
    step();
    step();
    check("rst_ren", 64'(mem_ren), 64'd0);
    check("rst_wen", 64'(mem_wen), 64'd0);
    check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("rst_bit_sel", mem_data_in_bit_sel, 64'd0);
    reset = 1'b0;
    step();

    // Single read of 0x100, tag 5.
    rd_req_valid = 1'b1; rd_req_addr = 17'h100; rd_req_tag = 4'd5;
    #1 check("rd1_ready", 64'(rd_req_ready), 64'd1);
    step();
    rd_req_valid = 1'b0;
    check("rd1_ren", 64'(mem_ren), 64'd1);
    check("rd1_addr", 64'(mem_addr), 64'h100);
    check("rd1_wen", 64'(mem_wen), 64'd0);
    step();
    check("rd1_ren_single", 64'(mem_ren), 64'd0);
    step();
    step();
    check("rd1_rsp_early", 64'(rd_rsp_valid), 64'd0);
    step();
    check("rd1_rsp_valid", 64'(rd_rsp_valid), 64'd1);
    check("rd1_rsp_tag", 64'(rd_rsp_tag), 64'd5);
    check("rd1_rsp_data", rd_rsp_data, init_word(32));
    step();
    check("rd1_rsp_single", 64'(rd_rsp_valid), 64'd0);

    // Partial write to 0x40, then an immediate read of the same word.
    wr_req_valid = 1'b1; wr_req_addr = 17'h40;
    wr_req_data = 64'h1122_3344_5566_7788; wr_req_strb = 8'h0F;
    #1 check("wr_ready", 64'(wr_req_ready), 64'd1);
    step();
    wr_req_valid = 1'b0;
    check("wr_wen", 64'(mem_wen), 64'd1);
    check("wr_ren", 64'(mem_ren), 64'd0);
    check("wr_bit_sel", mem_data_in_bit_sel, 64'h0000_0000_FFFF_FFFF);
    check("wr_data_in", mem_data_in, 64'h1122_3344_5566_7788);
    check("wr_addr", 64'(mem_addr), 64'h40);
    rd_req_valid = 1'b1; rd_req_addr = 17'h40; rd_req_tag = 4'd7;
    step();
    rd_req_valid = 1'b0;
    check("wr_wen_single", 64'(mem_wen), 64'd0);
    check("raw_ren", 64'(mem_ren), 64'd1);
    expect_rsp("raw", 4'd7, merged);

    // Starvation: both valid, write priority until the counter forces a read.
    wr_req_valid = 1'b1; wr_req_addr = 17'h80;
    wr_req_data = 64'hCAFE_F00D_0123_4567; wr_req_strb = 8'hFF;
    rd_req_valid = 1'b1; rd_req_addr = 17'h40; rd_req_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("starve_blocked%0d", i), 64'(rd_req_ready), 64'd0);
      step();
    end
    #1;
    check("starve_forced_rd", 64'(rd_req_ready), 64'd1);
    check("starve_forced_wr", 64'(wr_req_ready), 64'd0);
    step();
    check("starve_resume_rd", 64'(rd_req_ready), 64'd0);
    check("starve_resume_wr", 64'(wr_req_ready), 64'd1);
    check("starve_ren", 64'(mem_ren), 64'd1);
    check("starve_addr", 64'(mem_addr), 64'h40);
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b0;
    expect_rsp("starve", 4'd9, merged);

    // Zero-strobe write: handshake only.
    wr_req_valid = 1'b1; wr_req_addr = 17'h48; wr_req_data = '1; wr_req_strb = 8'h00;
    #1 check("zstrb_ready", 64'(wr_req_ready), 64'd1);
    step();
    wr_req_valid = 1'b0;
    check("zstrb_wen", 64'(mem_wen), 64'd0);
    check("zstrb_bit_sel", mem_data_in_bit_sel, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("zstrb_wen_after", 64'(mem_wen), 64'd0);

    // Four back-to-back reads, tags 1..4.
    b2b_exp[0] = init_word(32);
    b2b_exp[1] = init_word(33);
    b2b_exp[2] = init_word(34);
    b2b_exp[3] = merged;
    for (int i = 0; i < 4; i++) begin
      rd_req_valid = 1'b1;
      rd_req_addr  = (i == 3) ? 17'h40 : 17'(17'h100 + 8 * i);
      rd_req_tag   = 4'(i + 1);
      step();
    end
    rd_req_valid = 1'b0;
    check("b2b_rsp_early", 64'(rd_rsp_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("b2b_valid%0d", i), 64'(rd_rsp_valid), 64'd1);
      check($sformatf("b2b_tag%0d", i), 64'(rd_rsp_tag), 64'(i + 1));
      check($sformatf("b2b_data%0d", i), rd_rsp_data, b2b_exp[i]);
    end
    step();
    check("b2b_end", 64'(rd_rsp_valid), 64'd0);

    // Reset while a read is in flight.
    rd_req_valid = 1'b1; rd_req_addr = 17'h100; rd_req_tag = 4'hA;
    step();
    rd_req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_ren", 64'(mem_ren), 64'd0);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_data_in", mem_data_in, 64'd0);
    check("mid_rst_bit_sel", mem_data_in_bit_sel, 64'd0);
    check("mid_rst_tag", 64'(rd_rsp_tag), 64'd0);
    check("mid_rst_rsp", 64'(rd_rsp_valid), 64'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("post_rst_rsp%0d", i), 64'(rd_rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glb_bank_ctrl.md
Name: glb_bank_ctrl

Overview:
Request-side controller in front of each GLB bank memory. It arbitrates one write channel and one read channel (valid/ready) onto the single-port bank memory interface, and expands byte strobes into a bit-select mask. It registers all memory control outputs and tracks in-flight reads through a tag pipeline, so read data leaves with its tag exactly when the memory presents it.

Parameters:
BANK_ADDR_WIDTH, 17, byte address width of a bank
BANK_DATA_WIDTH, 64, bank word width in bits; must be a multiple of 8
BANK_BYTE_OFFSET, 3, log2(BANK_DATA_WIDTH/8); low address bits ignored by memory
MEM_RD_LATENCY, 3, edges from memory sampling ren to valid data_out
TAG_WIDTH, 4, read tag width
STARVE_MAX, 4, consecutive blocked-read cycles before a forced read grant; range 1..15

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
wr_req_valid  input  1  write request valid
wr_req_ready  output  1  write request accepted this cycle
wr_req_addr  input  BANK_ADDR_WIDTH  write byte address
wr_req_data  input  BANK_DATA_WIDTH  write data
wr_req_strb  input  BANK_DATA_WIDTH/8  byte enables
rd_req_valid  input  1  read request valid
rd_req_ready  output  1  read request accepted this cycle
rd_req_addr  input  BANK_ADDR_WIDTH  read byte address
rd_req_tag  input  TAG_WIDTH  tag returned with the response
rd_rsp_valid  output  1  response valid; no backpressure
rd_rsp_data  output  BANK_DATA_WIDTH  response data
rd_rsp_tag  output  TAG_WIDTH  response tag
mem_ren  output  1  memory read enable
mem_wen  output  1  memory write enable
mem_addr  output  BANK_ADDR_WIDTH  memory byte address
mem_data_in  output  BANK_DATA_WIDTH  memory write data
mem_data_in_bit_sel  output  BANK_DATA_WIDTH  per-bit write mask
mem_data_out  input  BANK_DATA_WIDTH  memory read data, held between reads

Behaviour:
- Reset (async, active-high): all mem_* outputs, rd_rsp_valid, rd_rsp_tag, the latency pipeline, starve_cnt and force_rd are cleared to 0. In-flight reads are discarded; no response is produced for them after reset is released.
- Arbitration: a combinational function of the valids and the force_rd register.
  - force_rd=0: wr_req_ready=1, rd_req_ready=~wr_req_valid.
  - force_rd=1: rd_req_ready=1, wr_req_ready=~rd_req_valid.
  - At most one request is accepted per cycle.
- Starvation counter (starve_cnt, 4 bits):
  - Increments on each edge with rd_req_valid & ~rd_req_ready.
  - Clears on any read acceptance.
  - When it reaches STARVE_MAX, force_rd is set and starve_cnt cleared.
  - force_rd clears on the next read acceptance. If rd_req_valid drops while force_rd=1, force_rd stays set until a read is accepted.
- Issue: at the acceptance edge E0, the mem_* registers load. mem_ren/mem_wen are high for exactly the one cycle after E0, otherwise 0. mem_addr and mem_data_in hold their last value when idle.
  - Write: mem_data_in=wr_req_data. mem_data_in_bit_sel byte i = {8{wr_req_strb[i]}}.
  - All-zero strobe: the write is accepted (handshake completes), but mem_wen stays 0 and no memory access occurs.
- Read pipeline: a shift register of depth 1+MEM_RD_LATENCY carries {valid, tag}. It is loaded at E0 on read acceptance.
  - rd_rsp_valid is high for exactly one cycle, starting 1+MEM_RD_LATENCY edges after E0 (default: the cycle after E4).
  - rd_rsp_tag is the pipeline output. rd_rsp_data = mem_data_out, passed through combinationally.
- Back-to-back reads: one accepted read per cycle gives one response per cycle, in order. A write between reads does not disturb pending responses.
- Ordering: memory accesses follow acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- Address low bits are passed through unchanged; the memory drops them.

Test Plan:
- Reset, then read of 0x100 tag 5 accepted at E0 -> mem_ren=1 only in cycle after E0 with mem_addr=0x100; rd_rsp_valid=1, tag=5 in cycle after E4 only.
- Write 0x40 data 0x1122334455667788, strb 0x0F -> mem_wen one cycle, bit_sel=0x00000000FFFFFFFF; subsequent read of 0x40 returns the merged word.
- wr_req_valid held high, rd_req_valid high from E0 -> rd_req_ready=0 for 4 cycles, then 1 for one cycle (read accepted), then write priority resumes.
- Write with strb=0 -> wr_req_ready=1, mem_wen stays 0, bit_sel unchanged.
- Four back-to-back reads, tags 1,2,3,4 -> four consecutive rd_rsp_valid cycles carrying tags 1,2,3,4.
- Assert reset two cycles after a read is accepted -> all outputs 0 immediately; no rd_rsp_valid after release.
